ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Drives the configuration-chain protocol that the routing blocks consume (ccff_head in, ccff_tail out, shifted on prog_clk).
- Accepts bitstream words over a valid/ready stream, serializes them LSB-first onto ccff_head, and asserts a shift-enable for the external prog_clk gate.
- Stops after exactly CHAIN_LEN bits.
- Sits between the eFPGA config controller and the head of one chain segment (e.g. one switch block's 46-bit chain).

Parameters:
- WORD_W, 32, input word width in bits (>=2).
- CHAIN_LEN, 46, number of config flops in the target chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the chain bit counter (derived, not overridden).

Ports:
- prog_clk  in  1  programming clock; all state on its rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- s_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- ccff_head  out  1  serial config bit to chain head.
- cfg_clk_en  out  1  chain shift enable (feeds the prog_clk ICG of the chain).
- ccff_tail  in  1  serial output of the chain tail.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when CHAIN_LEN bits have been shifted.
- rb_data  out  WORD_W  readback word (optional feature).
- rb_valid  out  1  rb_data valid pulse (optional feature).

Behaviour:
- Clock and reset: one clock, prog_clk. pReset is synchronous and active-high.
- Reset: state=IDLE; s_ready, cfg_clk_en, ccff_head, busy, done, rb_valid = 0; rb_data = 0; counters = 0.
- All outputs come from flops or decode of state/registers only. There is no combinational input-to-output path.
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE: start=1 -> FETCH next cycle; chain_cnt cleared. start is ignored in every other state.
- FETCH: s_ready=1. On s_valid&&s_ready:
  - s_data goes to shift_buf.
  - word_left = WORD_W.
  - -> SHIFT next cycle.
  - With no s_valid, stay in FETCH with cfg_clk_en=0 (chain holds).
- SHIFT: cfg_clk_en=1, ccff_head=shift_buf[0]. Each cycle:
  - shift_buf >>= 1.
  - word_left--.
  - chain_cnt++.
  - If chain_cnt reaches CHAIN_LEN this cycle -> DONE. Leftover bits of the current word are discarded.
  - Else if word_left reaches 0 -> FETCH.
  - s_ready=0 throughout SHIFT.
- DONE: done=1 for exactly one cycle, cfg_clk_en=0 -> IDLE.
- Latency per word: 1 FETCH cycle (when s_valid is already high) + WORD_W shift cycles.
- Total shift pulses per load is exactly CHAIN_LEN, never more.
- Boundaries:
  - CHAIN_LEN exact multiple of WORD_W: the last word is fully used, then DONE; no extra FETCH.
  - CHAIN_LEN < WORD_W: a single word; the upper bits are dropped.
  - start and pReset in the same cycle: reset wins.
  - pReset mid-load: IDLE next edge, cfg_clk_en=0, partial chain content undefined; no done pulse.
  - s_valid without a prior start: ignored (s_ready=0).
- Ordering: the first bit shifted ends up in the flop nearest ccff_tail. The bitstream generator orders the bits accordingly.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- When defined:
  - Each SHIFT cycle samples ccff_tail (the old chain content) LSB-first into rb_shift.
  - When WORD_W bits are collected, or at the last SHIFT cycle, rb_data is loaded and rb_valid pulses for 1 cycle the next cycle.
  - A partial final word is zero-padded in its upper bits.
  - rb has no backpressure.
  - With CHAIN_LEN=46 and WORD_W=32 this produces two pulses.
- When undefined: rb_data=0, rb_valid=0 constantly; no readback registers are synthesized.

Decomposition:
- Package ccff_pkg: state enum (IDLE, FETCH, SHIFT, DONE), default WORD_W/CHAIN_LEN constants, and a clog2-based counter-width function.
- One sub-module: ccff_serializer (shift_buf, word_left counter, load/shift controls, bit-0 output). The FSM and chain_cnt stay in the top.

Test Plan:
1. Reset: assert pReset for 2 cycles during SHIFT -> next edge state IDLE, cfg_clk_en=0, busy=0, no done pulse.
2. Basic load: CHAIN_LEN=46, WORD_W=32, start, words 0xA5A5_A5A5 then 0x0000_3FFF, s_valid always high. Required:
   - exactly 46 cfg_clk_en cycles, with a 1-cycle gap after bit 31;
   - the ccff_head sequence equals word0 bits 0..31 then word1 bits 0..13;
   - done pulses once; a 46-flop chain model holds the expected image.
3. Backpressure: hold s_valid low 5 cycles in FETCH between words -> cfg_clk_en=0 for those cycles; the chain image is unchanged versus test 2.
4. Exact multiple: CHAIN_LEN=64, two words -> 64 shifts, DONE directly after bit 63, no third s_ready.
5. Spurious inputs: start pulses while busy, and s_valid while IDLE -> no effect; the shift count stays exact.
6. With CCFF_READBACK_EN: preload the chain with a known pattern, then load a new image -> rb_valid pulses twice; rb_data equals the preloaded bits in tail order, and the second word's bits 14..31 are 0.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// ============================================================================
// Package     : ccff_pkg
// Description : Shared types and constants for the configuration-chain
//               loader: FSM state encoding, default word / chain sizes and
//               the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccff_pkg;

  // Loader FSM states, two-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  localparam int c_default_word_w    = 32;
  localparam int c_default_chain_len = 46;

  // Bits needed to hold every value in 0..max_val (never less than one).
  function automatic int ccff_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_chain_loader_if.sv
// ============================================================================
// Interface   : ccff_chain_loader_if
// Description : Valid/ready bitstream word stream feeding the loader.
// Signals     : s_data  - bitstream word, bit 0 shifted first
//               s_valid - s_data valid (driven by the source)
//               s_ready - loader accepts s_data (driven by the loader)
// Modports    : master (word source), slave (loader)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ccff_chain_loader_if
  import ccff_pkg::*;
#(
  parameter int WORD_W = c_default_word_w
) ();

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

`default_nettype wire

// File: rtl/ccff_chain_loader_serializer.sv
// ============================================================================
// Module      : ccff_serializer
// Description : Word-to-bit serializer. Holds the current bitstream word,
//               presents its bit 0 and shifts right once per shift request.
// Ports       : prog_clk   - programming clock
//               pReset     - synchronous active-high reset
//               i_load     - capture i_data, restart the per-word bit count
//               i_shift    - drop bit 0, advance to the next bit
//               i_data     - word to serialize
//               o_bit      - current serial bit (bit 0 of the buffer)
//               o_last_bit - the bit being presented is the word's last one
//               o_bit_idx  - position of the presented bit within its word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_serializer
  import ccff_pkg::*;
#(
  parameter  int WORD_W = c_default_word_w,
  localparam int WL_W   = ccff_cnt_w(WORD_W),
  localparam int IDX_W  = $clog2(WORD_W)
) (
  input  wire logic              prog_clk,
  input  wire logic              pReset,
  input  wire logic              i_load,
  input  wire logic              i_shift,
  input  wire logic [WORD_W-1:0] i_data,
  output logic                   o_bit,
  output logic                   o_last_bit,
  output logic [IDX_W-1:0]       o_bit_idx
);

  logic [WORD_W-1:0] shift_buf_d, shift_buf_q;
  logic [WL_W-1:0]   word_left_d, word_left_q;

  always_comb begin
    shift_buf_d = shift_buf_q;
    word_left_d = word_left_q;
    if (i_load) begin
      shift_buf_d = i_data;
      word_left_d = WL_W'(WORD_W);
    end else if (i_shift) begin
      shift_buf_d = shift_buf_q >> 1;
      word_left_d = word_left_q - WL_W'(1);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shift_buf_q <= '0;
      word_left_q <= '0;
    end else begin
      shift_buf_q <= shift_buf_d;
      word_left_q <= word_left_d;
    end
  end

  assign o_bit      = shift_buf_q[0];
  assign o_last_bit = (word_left_q == WL_W'(1));
  // Bits already consumed from the word equal the index of the current bit.
  assign o_bit_idx  = IDX_W'(WL_W'(WORD_W) - word_left_q);

endmodule

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// Module      : ccff_chain_loader
// Description : Loads one configuration-chain segment. Accepts bitstream
//               words over a valid/ready stream, serializes them LSB-first
//               onto ccff_head and enables the chain shift clock for exactly
//               CHAIN_LEN cycles per load.
// Ports       : prog_clk   - programming clock, all state on its rising edge
//               pReset     - synchronous active-high reset
//               start      - one-cycle load request, honoured only when idle
//               s_if       - word stream (slave side: s_data/s_valid/s_ready)
//               ccff_head  - serial bit into the chain head
//               cfg_clk_en - chain shift enable (drives the chain clock gate)
//               ccff_tail  - serial bit out of the chain tail
//               busy       - loader is not idle
//               done       - one-cycle pulse when the load completes
//               rb_data    - readback word (old chain content, tail first)
//               rb_valid   - one-cycle rb_data valid pulse
// Options     : CCFF_READBACK_EN - when defined, the old chain content is
//               captured from ccff_tail during shifting and returned on
//               rb_data/rb_valid; otherwise both outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter  int WORD_W    = c_default_word_w,
  parameter  int CHAIN_LEN = c_default_chain_len,
  localparam int CNT_W     = ccff_cnt_w(CHAIN_LEN),
  localparam int IDX_W     = $clog2(WORD_W)
) (
  input  wire logic        prog_clk,
  input  wire logic        pReset,
  input  wire logic        start,
  ccff_chain_loader_if.slave s_if,
  output logic             ccff_head,
  output logic             cfg_clk_en,
  input  wire logic        ccff_tail,
  output logic             busy,
  output logic             done,
  output logic [WORD_W-1:0] rb_data,
  output logic             rb_valid
);

  ccff_state_e      state_d, state_q;
  logic [CNT_W-1:0] chain_cnt_d, chain_cnt_q;

  logic             w_load;
  logic             w_shift;
  logic             w_chain_last;
  logic             w_word_last;
  logic             w_ser_bit;
  logic [IDX_W-1:0] w_bit_idx;

  // The bit being shifted now is the last one the chain needs.
  assign w_chain_last = (chain_cnt_q == CNT_W'(CHAIN_LEN - 1));

  always_comb begin
    state_d     = state_q;
    chain_cnt_d = chain_cnt_q;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          chain_cnt_d = '0;
        end
      end
      FETCH: begin
        // s_ready is high for the whole of FETCH, so valid alone completes the handshake.
        if (s_if.s_valid) begin
          w_load  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        w_shift     = 1'b1;
        chain_cnt_d = chain_cnt_q + CNT_W'(1);
        // Chain completion takes priority: leftover word bits are dropped.
        if (w_chain_last) begin
          state_d = DONE;
        end else if (w_word_last) begin
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= IDLE;
      chain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      chain_cnt_q <= chain_cnt_d;
    end
  end

  ccff_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (s_if.s_data),
    .o_bit      (w_ser_bit),
    .o_last_bit (w_word_last),
    .o_bit_idx  (w_bit_idx)
  );

  // All outputs decode registered state only.
  assign s_if.s_ready = (state_q == FETCH);
  assign cfg_clk_en   = (state_q == SHIFT);
  assign ccff_head    = cfg_clk_en & w_ser_bit;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_shift_d, rb_shift_q;
  logic [WORD_W-1:0] rb_data_d, rb_data_q;
  logic              rb_valid_d, rb_valid_q;

  // ccff_tail carries the old chain content while the new image shifts in.
  // Bits are placed by index so a short final word is naturally zero-padded.
  always_comb begin
    rb_shift_d = rb_shift_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (state_q == IDLE) begin
      rb_shift_d = '0;
    end
    if (w_shift) begin
      rb_shift_d[w_bit_idx] = ccff_tail;
      if (w_word_last || w_chain_last) begin
        rb_data_d  = rb_shift_d;
        rb_valid_d = 1'b1;
        rb_shift_d = '0;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      rb_shift_q <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_shift_q <= rb_shift_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  // Readback absent: the tail and bit index have no consumer.
  logic w_unused_rb;
  assign w_unused_rb = ^{ccff_tail, w_bit_idx};

  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Self-checking bench for ccff_chain_loader. Two loaders are
//               built (46-bit and 64-bit chains, 32-bit words), each driving
//               a behavioural flop-chain model whose tail feeds back.
// Options     : CCFF_READBACK_EN - also checks the readback words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccff_chain_loader;

  localparam int W  = 32;
  localparam int L0 = 46;
  localparam int L1 = 64;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic [1:0] start;
  logic [1:0] s_valid;
  logic [W-1:0] s_data [2];
  logic [1:0] clr;
  logic [1:0] preload;
  logic [63:0] preload_val;
  int         cyc = 0;

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Per-instance observations exported from the generate blocks.
  logic [1:0]   o_busy, o_cfg, o_head, o_done, o_ready, o_rbv;
  logic [W-1:0] o_rbd [2];
  int           m_shifts [2], m_dones [2], m_hs [2], m_readies [2];
  int           m_gap [2], m_dlat [2], m_rb_n [2];
  logic [63:0]  m_heads [2], m_chain [2];
  logic [W-1:0] m_rb [2][2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? L0 : L1;

    ccff_chain_loader_if #(.WORD_W(W)) bus ();
    logic         ccff_head, cfg_clk_en, ccff_tail, busy, done, rb_valid;
    logic [W-1:0] rb_data;
    logic [L-1:0] chain;
    logic [63:0]  heads;
    logic [W-1:0] rb_words [2];
    int           shifts, dones, hs, readies, rb_n, c31, c32, clast, done_cyc;

    assign bus.s_data  = s_data[g];
    assign bus.s_valid = s_valid[g];
    assign ccff_tail   = chain[L-1];

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
      .prog_clk   (prog_clk),
      .pReset     (pReset),
      .start      (start[g]),
      .s_if       (bus),
      .ccff_head  (ccff_head),
      .cfg_clk_en (cfg_clk_en),
      .ccff_tail  (ccff_tail),
      .busy       (busy),
      .done       (done),
      .rb_data    (rb_data),
      .rb_valid   (rb_valid)
    );

    always @(posedge prog_clk) begin
      if (clr[g]) begin
        shifts <= 0; dones <= 0; hs <= 0; readies <= 0; rb_n <= 0;
        heads <= '0; c31 <= 0; c32 <= 0; clast <= 0; done_cyc <= 0;
      end else begin
        if (cfg_clk_en) begin
          if (shifts < 64) heads[shifts[5:0]] <= ccff_head;
          if (shifts == 31) c31 <= cyc;
          if (shifts == 32) c32 <= cyc;
          clast  <= cyc;
          shifts <= shifts + 1;
        end
        if (done) begin
          dones    <= dones + 1;
          done_cyc <= cyc;
        end
        if (bus.s_ready) readies <= readies + 1;
        if (bus.s_ready && bus.s_valid) hs <= hs + 1;
        if (rb_valid) begin
          if (rb_n < 2) rb_words[rb_n[0]] <= rb_data;
          rb_n <= rb_n + 1;
        end
      end
      // Chain model: head enters bit 0, bit L-1 is the tail.
      if (preload[g]) chain <= preload_val[L-1:0];
      else if (cfg_clk_en) chain <= {chain[L-2:0], ccff_head};
    end

    assign o_busy[g]    = busy;
    assign o_cfg[g]     = cfg_clk_en;
    assign o_head[g]    = ccff_head;
    assign o_done[g]    = done;
    assign o_ready[g]   = bus.s_ready;
    assign o_rbv[g]     = rb_valid;
    assign o_rbd[g]     = rb_data;
    assign m_shifts[g]  = shifts;
    assign m_dones[g]   = dones;
    assign m_hs[g]      = hs;
    assign m_readies[g] = readies;
    assign m_gap[g]     = c32 - c31;
    assign m_dlat[g]    = done_cyc - clast;
    assign m_rb_n[g]    = rb_n;
    assign m_heads[g]   = heads;
    assign m_chain[g]   = 64'(chain);
    assign m_rb[g][0]   = rb_words[0];
    assign m_rb[g][1]   = rb_words[1];
  end

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [W-1:0] words [4];
  logic [63:0]  old_img [2];
  int           budget, sh;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bitstream order: word i/W, bit i%W, for the first L bits.
  function automatic logic [63:0] f_stream(input int L);
    logic [63:0]  b;
    logic [W-1:0] w;
    b = '0;
    for (int i = 0; i < L; i++) begin
      w    = words[i / W];
      b[i] = w[i % W];
    end
    return b;
  endfunction

  // Reverse the first L bits (stream index i <-> chain position L-1-i).
  function automatic logic [63:0] f_rev(input logic [63:0] v, input int L);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < L; j++) r[j] = v[L-1-j];
    return r;
  endfunction

  function automatic logic [63:0] f_mask(input int L);
    return (L >= 64) ? '1 : ((64'd1 << L) - 64'd1);
  endfunction

  task automatic do_preload(input int k, input logic [63:0] v, input int L);
    @(negedge prog_clk);
    preload[k]  = 1'b1;
    preload_val = v;
    @(negedge prog_clk);
    preload[k]  = 1'b0;
    old_img[k]  = v & f_mask(L);
  endtask

  task automatic run_load(input int k, input int nw, input int stall_n, input bit spurious);
    int bud;
    int stall_left;
    @(negedge prog_clk); clr[k] = 1'b1;
    @(negedge prog_clk); clr[k] = 1'b0;
    if (spurious) begin
      s_valid[k] = 1'b1;
      s_data[k]  = words[0];
      repeat (4) @(negedge prog_clk);
      chk("spur.idle_hs", 64'(m_hs[k]), 64'd0);
      chk("spur.idle_ready", 64'(m_readies[k]), 64'd0);
      chk("spur.idle_busy", 64'(o_busy[k]), 64'd0);
      s_valid[k] = 1'b0;
    end
    start[k] = 1'b1;
    @(negedge prog_clk);
    start[k]   = 1'b0;
    stall_left = stall_n;
    bud        = 400;
    while (m_dones[k] == 0 && bud > 0) begin
      if (o_ready[k] && m_hs[k] == 1 && stall_left > 0) begin
        s_valid[k] = 1'b0;
        stall_left--;
      end else begin
        s_valid[k] = (m_hs[k] < nw);
        s_data[k]  = words[m_hs[k][1:0]];
      end
      start[k] = (spurious && o_busy[k] && !o_done[k]) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge prog_clk);
      bud--;
    end
    start[k]   = 1'b0;
    s_valid[k] = 1'b0;
    chk("load.no_timeout", 64'(bud > 0), 64'd1);
    repeat (2) @(negedge prog_clk);
  endtask

  task automatic check_load(input int k, input int L, input int stall_n, input string nm);
    logic [63:0] b, img, r;
    int nrb;
    nrb = (L + W - 1) / W;
    b   = f_stream(L);
    img = f_rev(b, L);
    chk({nm, ".shifts"}, 64'(m_shifts[k]), 64'(L));
    chk({nm, ".done_pulses"}, 64'(m_dones[k]), 64'd1);
    chk({nm, ".head_seq"}, m_heads[k], b);
    chk({nm, ".chain_image"}, m_chain[k], img);
    chk({nm, ".handshakes"}, 64'(m_hs[k]), 64'(nrb));
    chk({nm, ".ready_cycles"}, 64'(m_readies[k]), 64'(nrb + stall_n));
    chk({nm, ".done_latency"}, 64'(m_dlat[k]), 64'd1);
    if (L > W) chk({nm, ".word_gap"}, 64'(m_gap[k]), 64'(2 + stall_n));
`ifdef CCFF_READBACK_EN
    r = f_rev(old_img[k], L);
    chk({nm, ".rb_pulses"}, 64'(m_rb_n[k]), 64'(nrb));
    chk({nm, ".rb_word0"}, 64'(m_rb[k][0]), 64'(r[W-1:0]));
    if (nrb > 1) chk({nm, ".rb_word1"}, 64'(m_rb[k][1]), 64'(r[2*W-1:W]));
`else
    r = '0;
    chk({nm, ".rb_pulses"}, 64'(m_rb_n[k]), 64'(r[0]));
    chk({nm, ".rb_data_zero"}, 64'(o_rbd[k]), 64'd0);
`endif
    old_img[k] = img;
  endtask

  initial begin
    pReset      = 1'b1;
    start       = '0;
    s_valid     = '0;
    s_data[0]   = '0;
    s_data[1]   = '0;
    clr         = 2'b11;
    preload     = 2'b11;
    preload_val = '0;
    old_img[0]  = '0;
    old_img[1]  = '0;
    repeat (3) @(negedge prog_clk);
    pReset  = 1'b0;
    clr     = '0;
    preload = '0;
    @(negedge prog_clk);

    // Reset state on both loaders.
    for (int k = 0; k < 2; k++) begin
      chk("rst.busy", 64'(o_busy[k]), 64'd0);
      chk("rst.s_ready", 64'(o_ready[k]), 64'd0);
      chk("rst.cfg_clk_en", 64'(o_cfg[k]), 64'd0);
      chk("rst.ccff_head", 64'(o_head[k]), 64'd0);
      chk("rst.done", 64'(o_done[k]), 64'd0);
      chk("rst.rb_valid", 64'(o_rbv[k]), 64'd0);
      chk("rst.rb_data", 64'(o_rbd[k]), 64'd0);
    end

    // Test 1: reset in the middle of SHIFT, then reset together with start.
    words[0] = $urandom;
    words[1] = $urandom;
    @(negedge prog_clk); clr[0] = 1'b1;
    @(negedge prog_clk); clr[0] = 1'b0;
    start[0]   = 1'b1;
    s_valid[0] = 1'b1;
    s_data[0]  = words[0];
    @(negedge prog_clk);
    start[0] = 1'b0;
    budget   = 200;
    while (m_shifts[0] < 10 && budget > 0) begin
      @(negedge prog_clk);
      budget--;
    end
    chk("t1.reached_shift", 64'(budget > 0), 64'd1);
    pReset = 1'b1;
    @(negedge prog_clk);
    chk("t1.busy", 64'(o_busy[0]), 64'd0);
    chk("t1.cfg_clk_en", 64'(o_cfg[0]), 64'd0);
    chk("t1.s_ready", 64'(o_ready[0]), 64'd0);
    sh = m_shifts[0];
    @(negedge prog_clk);
    pReset     = 1'b0;
    s_valid[0] = 1'b0;
    repeat (5) @(negedge prog_clk);
    chk("t1.no_done", 64'(m_dones[0]), 64'd0);
    chk("t1.no_more_shifts", 64'(m_shifts[0]), 64'(sh));
    start[0] = 1'b1;
    pReset   = 1'b1;
    @(negedge prog_clk);
    start[0] = 1'b0;
    pReset   = 1'b0;
    chk("t1.reset_wins", 64'(o_busy[0]), 64'd0);
    @(negedge prog_clk);
    chk("t1.still_idle", 64'(o_busy[0]), 64'd0);

    // Test 2: fixed words on the 46-bit chain, source always valid.
    do_preload(0, {$urandom, $urandom}, L0);
    words[0] = 32'hA5A5_A5A5;
    words[1] = 32'h0000_3FFF;
    run_load(0, 2, 0, 1'b0);
    check_load(0, L0, 0, "t2");
`ifdef CCFF_READBACK_EN
    chk("t2.rb_word1_pad", 64'(m_rb[0][1][31:14]), 64'd0);
`endif

    // Test 3: same words, five idle FETCH cycles between them.
    run_load(0, 2, 5, 1'b0);
    check_load(0, L0, 5, "t3");

    // Test 4: 64-bit chain, exact multiple of the word width.
    do_preload(1, {$urandom, $urandom}, L1);
    words[0] = $urandom;
    words[1] = $urandom;
    run_load(1, 2, 0, 1'b0);
    check_load(1, L1, 0, "t4");

    // Test 5: spurious valid while idle and start pulses while busy.
    words[0] = $urandom;
    words[1] = $urandom;
    run_load(0, 2, 0, 1'b1);
    check_load(0, L0, 0, "t5");

    // Randomized loads on both chain lengths.
    for (int it = 0; it < 6; it++) begin
      int k;
      int st;
      k  = it % 2;
      st = $urandom_range(0, 3);
      if (it >= 4) do_preload(k, {$urandom, $urandom}, (k == 0) ? L0 : L1);
      words[0] = $urandom;
      words[1] = $urandom;
      run_load(k, 2, st, 1'(it % 3 == 0));
      check_load(k, (k == 0) ? L0 : L1, st, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
